// File: rtl/retire_trace_buffer.sv
// Retire trace capture FIFO. Timestamps each WB-stage retirement, appends one exit
// record, and lets the host drain records over valid/ready. Overflow either drops or overwrites.
module retire_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int TS_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture_en,
  input  logic                    wb_instr_retired,
  input  logic [31:0]             wb_pc,
  input  logic [31:0]             wb_instr,
  input  logic                    wb_rd_write,
  input  logic [31:0]             wb_rd_data,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    csr_valid,
  input  logic [11:0]             csr_addr,
  input  logic [31:0]             csr_wdata,
  input  logic                    exit_request,
  input  logic [31:0]             exit_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_rd_data,
  output logic [31:0]             out_addr,
  output logic [31:0]             out_data,
  output logic [7:0]              out_flags,
  output logic [TS_WIDTH-1:0]     out_ts,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             drop_count,
  output logic                    stopped
);
  localparam int AW = $clog2(DEPTH);
  localparam bit OW = (OVERWRITE != 0);

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [31:0]         rd_data;
    logic [31:0]         addr;
    logic [31:0]         data;
    logic [7:0]          flags;
    logic [TS_WIDTH-1:0] ts;
  } rec_t;

  rec_t                mem [DEPTH];
  rec_t                rec;
  rec_t                head;
  logic [AW-1:0]       wptr, rptr;
  logic [TS_WIDTH-1:0] ts;
  logic [31:0]         last_pc;
  logic                exit_q, exit_pending, gap_pending;
  logic                cap, pop, full, space, exit_push, push, write, drop;

  always_comb begin
    cap       = wb_instr_retired && capture_en && !stopped;
    pop       = out_valid && out_ready;
    full      = (level == (AW+1)'(DEPTH));
    // a same-cycle pop frees the slot, so a full FIFO still accepts without loss
    space     = !full || pop;
    exit_push = exit_pending && !cap && space;
    push      = cap || exit_push;
    write     = push && (space || OW);
    drop      = push && !space;
    rec       = '0;
    if (cap) begin
      rec.pc       = wb_pc;
      rec.instr    = wb_instr;
      rec.rd_data  = wb_rd_write ? wb_rd_data : 32'd0;
      rec.flags[0] = wb_rd_write;
      rec.flags[1] = mem_read;
      rec.flags[2] = mem_write;
      rec.flags[3] = csr_valid;
      rec.ts       = ts;
      if (mem_write) begin
        rec.addr = mem_addr;
        rec.data = mem_wdata;
      end else if (mem_read) begin
        rec.addr = mem_addr;
        rec.data = mem_rdata;
      end else if (csr_valid) begin
        rec.addr = {20'b0, csr_addr};
        rec.data = csr_wdata;
      end
    end else if (exit_push) begin
      rec.pc       = last_pc;
      rec.data     = exit_code;
      rec.flags[4] = 1'b1;
    end
    rec.flags[5] = gap_pending || (drop && OW);
  end

  // slot storage carries no reset; out_valid gates every read of it
  always_ff @(posedge clk) begin
    if (write) mem[wptr] <= rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      drop_count   <= '0;
      ts           <= '0;
      last_pc      <= '0;
      exit_q       <= 1'b0;
      exit_pending <= 1'b0;
      gap_pending  <= 1'b0;
      stopped      <= 1'b0;
    end else begin
      ts     <= ts + TS_WIDTH'(1);
      exit_q <= exit_request;
      if (write) wptr <= wptr + AW'(1);
      if (pop || (drop && OW)) rptr <= rptr + AW'(1);
      if (write && space && !pop) level <= level + (AW+1)'(1);
      else if (pop && !(write && space)) level <= level - (AW+1)'(1);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (drop && !OW) gap_pending <= 1'b1;
      else if (write) gap_pending <= 1'b0;
      if (cap) last_pc <= wb_pc;
      if (exit_push) begin
        exit_pending <= 1'b0;
        stopped      <= 1'b1;
      end else if (exit_request && !exit_q && !stopped) begin
        exit_pending <= 1'b1;
      end
    end
  end

  assign out_valid = (level != '0);
  assign head      = mem[rptr];

  always_comb begin
    out_pc      = '0;
    out_instr   = '0;
    out_rd_data = '0;
    out_addr    = '0;
    out_data    = '0;
    out_flags   = '0;
    out_ts      = '0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_instr   = head.instr;
      out_rd_data = head.rd_data;
      out_addr    = head.addr;
      out_data    = head.data;
      out_flags   = head.flags;
      out_ts      = head.ts;
    end
  end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: drop (OVERWRITE=0) and overwrite (OVERWRITE=1)
// instances share stimulus; each has its own queue-based reference model and monitor.
module tb_retire_trace_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  flags;
    logic [31:0] ts;
  } trec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en, wb_instr_retired, wb_rd_write, mem_read, mem_write, csr_valid;
  logic        exit_request, out_ready;
  logic [31:0] wb_pc, wb_instr, wb_rd_data, mem_addr, mem_wdata, mem_rdata, csr_wdata, exit_code;
  logic [11:0] csr_addr;

  logic        ov [2];
  logic [31:0] opc [2], oin [2], ord [2], oad [2], oda [2], ots [2];
  logic [7:0]  ofl [2];
  logic [4:0]  olev [2];
  logic [15:0] odrop [2];
  logic        ostop [2];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected retire record straight from the field rules: mem beats csr, store beats load.
  function automatic trec_t retire_rec(input logic [31:0] stamp);
    trec_t r;
    r       = '0;
    r.pc    = wb_pc;
    r.instr = wb_instr;
    r.rd    = wb_rd_write ? wb_rd_data : 32'd0;
    r.flags = {4'b0, csr_valid, mem_write, mem_read, wb_rd_write};
    r.ts    = stamp;
    if (mem_write)      begin r.addr = mem_addr;          r.data = mem_wdata; end
    else if (mem_read)  begin r.addr = mem_addr;          r.data = mem_rdata; end
    else if (csr_valid) begin r.addr = {20'b0, csr_addr}; r.data = csr_wdata; end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit OW = (g != 0);

    retire_trace_buffer #(.DEPTH(16), .OVERWRITE(g), .TS_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .capture_en(capture_en),
      .wb_instr_retired(wb_instr_retired), .wb_pc(wb_pc), .wb_instr(wb_instr),
      .wb_rd_write(wb_rd_write), .wb_rd_data(wb_rd_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .exit_request(exit_request), .exit_code(exit_code),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_pc(opc[g]), .out_instr(oin[g]), .out_rd_data(ord[g]),
      .out_addr(oad[g]), .out_data(oda[g]), .out_flags(ofl[g]), .out_ts(ots[g]),
      .level(olev[g]), .drop_count(odrop[g]), .stopped(ostop[g])
    );

    trec_t       sb [$];
    trec_t       r;
    int          mlevel, mdrop;
    logic [31:0] mts, mlast;
    bit          mstop, mpend, mgap, mprev, m_pop, m_cap, m_space, m_ex;

    // reference model: buffer contents live in sb; the monitor consumes its head
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        mlevel = 0; mdrop = 0; mts = 0; mlast = 0;
        mstop = 0; mpend = 0; mgap = 0; mprev = 0;
      end else begin
        m_pop   = (mlevel > 0) && out_ready;
        m_cap   = wb_instr_retired && capture_en && !mstop;
        m_space = (mlevel < 16) || m_pop;
        m_ex    = mpend && !m_cap && m_space;
        if (m_cap) r = retire_rec(mts);
        else begin
          r = '0; r.pc = mlast; r.data = exit_code; r.flags = 8'h10;
        end
        if (m_cap || m_ex) begin
          if (m_space) begin
            r.flags[5] = mgap; mgap = 0;
            sb.push_back(r);
            if (!m_pop) mlevel++;
          end else if (OW) begin
            r.flags[5] = 1'b1;
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(r);
            if (mdrop < 16'hFFFF) mdrop++;
          end else begin
            mgap = 1;
            if (mdrop < 16'hFFFF) mdrop++;
          end
        end else if (m_pop) mlevel--;
        if (m_cap) mlast = wb_pc;
        if (m_ex) begin mstop = 1; mpend = 0; end
        else if (exit_request && !mprev && !mstop) mpend = 1;
        mprev = exit_request;
        mts++;
      end
    end

    // monitor: compares status every cycle and the head record whenever one is presented
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        chk($sformatf("ow%0d level", g), 256'(olev[g]), 256'(mlevel));
        chk($sformatf("ow%0d drop_count", g), 256'(odrop[g]), 256'(mdrop));
        chk($sformatf("ow%0d stopped", g), 256'(ostop[g]), 256'(mstop));
        chk($sformatf("ow%0d out_valid", g), 256'(ov[g]), 256'(mlevel > 0));
        if (!ov[g]) begin
          chk($sformatf("ow%0d idle fields", g),
              256'({opc[g], oin[g], ord[g], oad[g], oda[g], ofl[g], ots[g]}), 256'(0));
        end else if (sb.size() > 0) begin
          chk($sformatf("ow%0d record", g),
              256'({opc[g], oin[g], ord[g], oad[g], oda[g], ofl[g], ots[g]}), 256'(sb[0]));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wb_instr_retired = 0; wb_pc = 0; wb_instr = 0; wb_rd_write = 0; wb_rd_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    csr_valid = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic retire_plain(input logic [31:0] pc);
    clr_in();
    wb_instr_retired = 1; wb_pc = pc; wb_instr = pc ^ 32'h13;
    wb_rd_write = 1; wb_rd_data = pc + 32'd1;
    tick();
    clr_in();
  endtask

  task automatic rand_in();
    int k;
    clr_in();
    capture_en       = ($urandom % 8) != 0;
    wb_instr_retired = $urandom % 2;
    wb_pc = $urandom; wb_instr = $urandom;
    wb_rd_write = $urandom % 2; wb_rd_data = $urandom;
    k = $urandom % 4;
    mem_read  = (k == 1);
    mem_write = (k == 2);
    mem_addr = $urandom; mem_wdata = $urandom; mem_rdata = $urandom;
    csr_valid = ($urandom % 4) == 0; csr_addr = 12'($urandom); csr_wdata = $urandom;
  endtask

  initial begin
    rst_n = 0; clr_in(); capture_en = 1; out_ready = 0; exit_request = 0; exit_code = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("ow%0d reset out_valid", g), 256'(ov[g]), 256'(0));
      chk($sformatf("ow%0d reset level", g), 256'(olev[g]), 256'(0));
      chk($sformatf("ow%0d reset drop", g), 256'(odrop[g]), 256'(0));
      chk($sformatf("ow%0d reset stopped", g), 256'(ostop[g]), 256'(0));
      chk($sformatf("ow%0d reset out_pc", g), 256'(opc[g]), 256'(0));
    end
    rst_n = 1;

    // three back-to-back retires, first sampled at timestamp 5
    repeat (5) tick();
    out_ready = 1;
    for (int i = 0; i < 3; i++) retire_plain(32'h8000_0000 + 32'(i * 4));
    repeat (3) tick();

    // overflow: 20 retires into a stalled 16-deep FIFO
    out_ready = 0;
    for (int i = 1; i <= 20; i++) retire_plain(32'h1000 + 32'(i * 4));
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("ow%0d overflow level", g), 256'(olev[g]), 256'(16));
      chk($sformatf("ow%0d overflow drop", g), 256'(odrop[g]), 256'(4));
    end
    out_ready = 1;
    repeat (20) tick();
    retire_plain(32'h100);
    repeat (3) tick();

    // store followed by CSRRW mtvec
    clr_in(); wb_instr_retired = 1; wb_pc = 32'h200; wb_instr = 32'h00f12023;
    mem_write = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
    tick();
    clr_in(); wb_instr_retired = 1; wb_pc = 32'h204; wb_instr = 32'h30529073;
    csr_valid = 1; csr_addr = 12'h305; csr_wdata = 32'h8000_0100;
    tick();
    clr_in();
    repeat (3) tick();

    // full FIFO with push and pop together for 10 cycles
    out_ready = 0;
    for (int i = 0; i < 16; i++) retire_plain(32'h4000 + 32'(i * 4));
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      clr_in(); wb_instr_retired = 1; wb_pc = 32'h5000 + 32'(i * 4); wb_instr = 32'h13;
      tick();
      for (int g = 0; g < 2; g++)
        chk($sformatf("ow%0d push+pop level", g), 256'(olev[g]), 256'(16));
    end
    clr_in();
    for (int g = 0; g < 2; g++)
      chk($sformatf("ow%0d push+pop drop", g), 256'(odrop[g]), 256'(4));
    repeat (20) tick();

    // randomized traffic with alternating host back-pressure
    for (int i = 0; i < 1200; i++) begin
      rand_in();
      out_ready = ($urandom % 4) < (((i / 200) % 2) != 0 ? 1 : 3);
      tick();
    end

    // reset asserted mid-stream
    capture_en = 1; out_ready = 0;
    for (int i = 0; i < 16; i++) retire_plain(32'h6000 + 32'(i * 4));
    out_ready = 1;
    for (int i = 0; i < 5; i++) retire_plain(32'h7000 + 32'(i * 4));
    wb_instr_retired = 1; wb_pc = 32'h7100;
    #3 rst_n = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("ow%0d midreset out_valid", g), 256'(ov[g]), 256'(0));
      chk($sformatf("ow%0d midreset level", g), 256'(olev[g]), 256'(0));
      chk($sformatf("ow%0d midreset drop", g), 256'(odrop[g]), 256'(0));
      chk($sformatf("ow%0d midreset out_pc", g), 256'(opc[g]), 256'(0));
    end
    clr_in();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 200; i++) begin
      rand_in();
      out_ready = ($urandom % 2) != 0;
      tick();
    end

    // exit request rising together with a retire
    clr_in(); capture_en = 1; out_ready = 1;
    repeat (20) tick();
    wb_instr_retired = 1; wb_pc = 32'h3000; wb_instr = 32'h73;
    exit_request = 1; exit_code = 32'h1;
    tick();
    clr_in();
    repeat (2) tick();
    for (int i = 0; i < 3; i++) retire_plain(32'h3100 + 32'(i * 4));
    for (int g = 0; g < 2; g++)
      chk($sformatf("ow%0d exit stopped", g), 256'(ostop[g]), 256'(1));
    exit_request = 0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
